ws2812b_rx: RTL and testbench

//  Receive-side decoder for the WS2812B single-wire LED protocol. Samples an incoming strip

---
 rtl/ws2812b_rx.sv | 174 +++++++++++++++++
 tb/tb_ws2812b_rx.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/ws2812b_rx.sv
// WS2812B receive decoder: classifies high-pulse widths, assembles 24-bit GRB words MSB-first,
// flags the latch gap, and regenerates the line downstream once a frame's first word is consumed.
module ws2812b_rx #(
  parameter int THRESH_CYCLES = 12,
  parameter int MIN_HIGH      = 3,
  parameter int MAX_HIGH      = 40,
  parameter int RESET_CYCLES  = 1000
) (
  input  logic        clk20,
  input  logic        reset_n,
  input  logic        din,
  output logic [23:0] data_out,
  output logic        valid,
  output logic        latch,
  output logic        error,
  output logic        busy,
  output logic        dout
);

  localparam logic [15:0] THRESH_C = 16'(THRESH_CYCLES);
  localparam logic [15:0] MIN_C    = 16'(MIN_HIGH);
  localparam logic [15:0] MAX_C    = 16'(MAX_HIGH);
  localparam logic [15:0] RESET_C  = 16'(RESET_CYCLES);

  typedef enum logic [1:0] {SYNC, IDLE, HIGH, LOW} state_t;

  state_t      state_q, state_d;
  logic        sync1_q, sync1_d;
  logic        sync2_q, sync2_d;
  logic [15:0] cnt_q, cnt_d;
  logic [4:0]  bitcnt_q, bitcnt_d;
  logic [23:0] word_q, word_d;
  logic [23:0] data_q, data_d;
  logic        fwd_q, fwd_d;
  logic        valid_q, valid_d;
  logic        latch_q, latch_d;
  logic        error_q, error_d;
  logic        busy_q, busy_d;
  logic        dout_q, dout_d;

  logic        din_s;
  logic [15:0] cnt_inc;
  logic        bit_val;
  logic [23:0] word_shift;
  logic        abort;

  assign din_s      = sync2_q;
  assign cnt_inc    = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
  assign bit_val    = (cnt_q >= THRESH_C);
  assign word_shift = {word_q[22:0], bit_val};
  // In HIGH, cnt_q is the width so far: too long while still high, or too short at the fall.
  assign abort      = din_s ? (cnt_q >= MAX_C) : (cnt_q < MIN_C);

  always_comb begin
    state_d  = state_q;
    sync1_d  = din;
    sync2_d  = sync1_q;
    cnt_d    = cnt_q;
    bitcnt_d = bitcnt_q;
    word_d   = word_q;
    data_d   = data_q;
    fwd_d    = fwd_q;
    valid_d  = 1'b0;
    latch_d  = 1'b0;
    error_d  = 1'b0;

    case (state_q)
      SYNC: begin
        if (din_s) begin
          cnt_d = 16'd0;
        end else if (cnt_inc >= RESET_C) begin
          state_d = IDLE;
          cnt_d   = 16'd0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      IDLE: begin
        if (din_s) begin
          state_d = HIGH;
          cnt_d   = 16'd1;
        end
      end
      HIGH: begin
        if (abort) begin
          state_d  = SYNC;
          error_d  = 1'b1;
          cnt_d    = 16'd0;
          bitcnt_d = 5'd0;
          word_d   = 24'd0;
          fwd_d    = 1'b0;
        end else if (din_s) begin
          cnt_d = cnt_inc;
        end else begin
          state_d = LOW;
          cnt_d   = 16'd1;
          if (bitcnt_q == 5'd23) begin
            data_d   = word_shift;
            valid_d  = 1'b1;
            bitcnt_d = 5'd0;
            word_d   = 24'd0;
            fwd_d    = 1'b1;
          end else begin
            word_d   = word_shift;
            bitcnt_d = bitcnt_q + 5'd1;
          end
        end
      end
      LOW: begin
        if (din_s) begin
          state_d = HIGH;
          cnt_d   = 16'd1;
        end else if (cnt_inc == RESET_C) begin
          state_d  = IDLE;
          latch_d  = 1'b1;
          error_d  = (bitcnt_q != 5'd0);
          cnt_d    = 16'd0;
          bitcnt_d = 5'd0;
          word_d   = 24'd0;
          fwd_d    = 1'b0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = SYNC;
        cnt_d   = 16'd0;
      end
    endcase

    busy_d = (state_d == HIGH) || (state_d == LOW);
    dout_d = fwd_q & din_s;
  end

  always_ff @(posedge clk20) begin
    if (!reset_n) begin
      state_q  <= SYNC;
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      cnt_q    <= 16'd0;
      bitcnt_q <= 5'd0;
      word_q   <= 24'd0;
      data_q   <= 24'd0;
      fwd_q    <= 1'b0;
      valid_q  <= 1'b0;
      latch_q  <= 1'b0;
      error_q  <= 1'b0;
      busy_q   <= 1'b0;
      dout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      cnt_q    <= cnt_d;
      bitcnt_q <= bitcnt_d;
      word_q   <= word_d;
      data_q   <= data_d;
      fwd_q    <= fwd_d;
      valid_q  <= valid_d;
      latch_q  <= latch_d;
      error_q  <= error_d;
      busy_q   <= busy_d;
      dout_q   <= dout_d;
    end
  end

  assign data_out = data_q;
  assign valid    = valid_q;
  assign latch    = latch_q;
  assign error    = error_q;
  assign busy     = busy_q;
  assign dout     = dout_q;

endmodule

// File: tb/tb_ws2812b_rx.sv
// Directed bench for ws2812b_rx: table of whole frames plus hand-written glitch, stuck-high,
// forwarding and mid-frame reset sequences.
module tb_ws2812b_rx;

  logic        clk20 = 1'b0;
  logic        reset_n;
  logic        din;
  logic [23:0] data_out;
  logic        valid, latch, error, busy, dout;

  always #5 clk20 = ~clk20;

  ws2812b_rx dut (
    .clk20   (clk20),
    .reset_n (reset_n),
    .din     (din),
    .data_out(data_out),
    .valid   (valid),
    .latch   (latch),
    .error   (error),
    .busy    (busy),
    .dout    (dout)
  );

  typedef struct {
    logic [23:0] word;
    int          nbits;
    int          t0h;
    int          t1h;
    int          per;
    logic [23:0] exp_data;
    int          exp_valid;
    int          exp_err;
  } vec_t;

  vec_t        tbl [5];
  int          cyc = 0;
  logic [2:0]  dh = 3'b000;
  int          n_valid = 0, n_latch = 0, n_err = 0, both_cnt = 0;
  int          dout_bad = 0, dout_ones = 0;
  int          valid_cyc = 0, latch_cyc = 0, err_cyc = 0;
  logic        fwd_m = 1'b0;
  logic [23:0] words [$];
  int          passed = 0, total = 0;
  int          last_fall = 0;

  always @(posedge clk20) begin
    cyc <= cyc + 1;
    dh  <= {dh[1:0], din};
  end

  // Observed pulses; dout is expected to follow din delayed 3 cycles once a word has been seen.
  always @(negedge clk20) begin
    if (!reset_n) begin
      fwd_m = 1'b0;
    end else begin
      if (dout !== (fwd_m ? dh[2] : 1'b0)) dout_bad++;
      if (dout === 1'b1) dout_ones++;
      if (valid && error) both_cnt++;
      if (valid) begin
        n_valid++;
        valid_cyc = cyc;
        words.push_back(data_out);
        fwd_m = 1'b1;
      end
      if (latch) begin
        n_latch++;
        latch_cyc = cyc;
        fwd_m = 1'b0;
      end
      if (error) begin
        n_err++;
        err_cyc = cyc;
        fwd_m = 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic send_bit(input logic b, input int t0h, input int t1h, input int per);
    int h;
    h = b ? t1h : t0h;
    din = 1'b1;
    repeat (h) @(negedge clk20);
    din = 1'b0;
    last_fall = cyc;
    repeat (per - h) @(negedge clk20);
  endtask

  task automatic send_word(input logic [23:0] w, input int nbits, input int t0h, input int t1h,
                           input int per);
    for (int i = 0; i < nbits; i++) send_bit(w[23-i], t0h, t1h, per);
  endtask

  task automatic hold_low(input int n);
    din = 1'b0;
    repeat (n) @(negedge clk20);
  endtask

  initial begin
    int v0, l0, e0, fall, rise, exp_ones;
    logic [23:0] w2;

    tbl[0] = '{24'hA53C0F, 24, 8, 16, 25, 24'hA53C0F, 1, 0};
    tbl[1] = '{24'hF0F0F0, 24, 11, 12, 25, 24'hF0F0F0, 1, 0};
    tbl[2] = '{24'h5A5A5A, 24, 3, 40, 50, 24'h5A5A5A, 1, 0};
    tbl[3] = '{24'hC3C3C3, 10, 8, 16, 25, 24'h5A5A5A, 0, 1};
    tbl[4] = '{24'h800001, 24, 8, 16, 25, 24'h800001, 1, 0};

    reset_n = 1'b0;
    din     = 1'b0;
    repeat (3) @(negedge clk20);
    check("reset data_out", data_out, 24'h0);
    check("reset ctrl", {valid, latch, error, busy, dout}, 5'b0);
    reset_n = 1'b1;
    hold_low(1005);

    for (int i = 0; i < 5; i++) begin
      v0 = n_valid; l0 = n_latch; e0 = n_err;
      send_word(tbl[i].word, tbl[i].nbits, tbl[i].t0h, tbl[i].t1h, tbl[i].per);
      fall = last_fall;
      hold_low(1010);
      check($sformatf("v%0d data_out", i), data_out, tbl[i].exp_data);
      check($sformatf("v%0d valid count", i), n_valid - v0, tbl[i].exp_valid);
      check($sformatf("v%0d error count", i), n_err - e0, tbl[i].exp_err);
      check($sformatf("v%0d latch count", i), n_latch - l0, 1);
      check($sformatf("v%0d latch latency", i), latch_cyc - fall, 1002);
      if (tbl[i].exp_valid == 1) check($sformatf("v%0d valid latency", i), valid_cyc - fall, 3);
      else check($sformatf("v%0d error with latch", i), err_cyc, latch_cyc);
    end

    // Glitch: 2-cycle high aborts; a following frame is ignored until a full gap is seen.
    v0 = n_valid; l0 = n_latch; e0 = n_err;
    send_word(24'hFFFFFF, 5, 8, 16, 25);
    send_bit(1'b0, 2, 16, 25);
    check("glitch error", n_err - e0, 1);
    send_word(24'h777777, 24, 8, 16, 25);
    hold_low(1010);
    check("glitch no valid", n_valid - v0, 0);
    check("glitch no latch", n_latch - l0, 0);
    check("glitch data held", data_out, 24'h800001);
    send_word(24'h3C3C3C, 24, 8, 16, 25);
    hold_low(1010);
    check("post-glitch data", data_out, 24'h3C3C3C);
    check("post-glitch valid", n_valid - v0, 1);

    // Stuck high: error once the high reaches 41 cycles, back to SYNC.
    e0 = n_err; l0 = n_latch;
    din  = 1'b1;
    rise = cyc;
    repeat (10) @(negedge clk20);
    check("busy while high", busy, 1'b1);
    repeat (50) @(negedge clk20);
    check("stuck error count", n_err - e0, 1);
    check("stuck error latency", err_cyc - rise, 43);
    check("busy after stuck", busy, 1'b0);
    hold_low(1010);
    check("no latch from sync", n_latch - l0, 0);

    // Two words: second is forwarded on dout.
    words.delete();
    dout_ones = 0;
    v0 = n_valid;
    send_word(24'h123456, 24, 8, 16, 25);
    w2 = 24'hABCDEF;
    send_word(w2, 24, 8, 16, 25);
    hold_low(1010);
    exp_ones = 0;
    for (int i = 0; i < 24; i++) exp_ones += w2[i] ? 16 : 8;
    check("two valids", n_valid - v0, 2);
    check("word 0", (words.size() > 0) ? words[0] : 24'hx, 24'h123456);
    check("word 1", (words.size() > 1) ? words[1] : 24'hx, 24'hABCDEF);
    check("dout high cycles", dout_ones, exp_ones);
    check("dout low after latch", dout, 1'b0);

    // Reset during bit 12.
    v0 = n_valid; l0 = n_latch; e0 = n_err;
    send_word(24'hFEDCBA, 11, 8, 16, 25);
    din = 1'b1;
    repeat (5) @(negedge clk20);
    check("busy mid-frame", busy, 1'b1);
    reset_n = 1'b0;
    @(negedge clk20);
    check("mid reset data_out", data_out, 24'h0);
    check("mid reset ctrl", {valid, latch, error, busy, dout}, 5'b0);
    reset_n = 1'b1;
    repeat (11) @(negedge clk20);
    hold_low(9);
    for (int i = 12; i < 24; i++) send_bit(w2[23-i], 8, 16, 25);
    hold_low(1010);
    check("after reset no valid", n_valid - v0, 0);
    check("after reset no latch", n_latch - l0, 0);
    check("after reset no error", n_err - e0, 0);
    send_word(24'h0F1E2D, 24, 8, 16, 25);
    hold_low(1010);
    check("after reset data", data_out, 24'h0F1E2D);
    check("after reset valid", n_valid - v0, 1);

    check("valid/error overlap", both_cnt, 0);
    check("dout tracking", dout_bad, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
